mem_port_arbiter: RTL and testbench

- Sequences the single unified instruction/data memory between two requesters: the IF-stage fetch port and the MEM-stage load/store port.
- Grants one access at a time and holds the memory address, write-enable and write-data lines stable for the access.
- Returns read data with a valid pulse, and drives stall_if/stall_mem so the pipeline holds while its request is pending.
- Sits between the pipeline stages and the memory block; the memory stays combinational-read and write-on-enable.

---
 rtl/mem_port_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one combinational-read, write-on-enable memory between the fetch port and the load/store port.
// Optional trace of grants and out-of-range accesses: define MEM_ARB_TRACE_EN.
module mem_port_arbiter #(
  parameter logic [31:0] ADDR_LO      = 32'h00400000,
  parameter logic [31:0] ADDR_HI      = 32'h0041FFFF,
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        stall_if,
  output logic        stall_mem,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        err_oob
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic [3:0] LAT_LOAD   = 4'(MEM_LATENCY - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t      state_q, state_d;
  logic [3:0]  lat_q, lat_d;
  logic [3:0]  starve_q, starve_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_we_q, mem_we_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic        d_valid_q, d_valid_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        err_oob_q, err_oob_d;

  logic d_oob;
  logic pick_i;
  logic pick_d;
  logic grant_i;
  logic grant_d;
  logic oob_hit;

  // Data normally wins (it belongs to the older instruction) until fetch has waited STARVE_LIMIT grants.
  assign d_oob   = (d_addr < ADDR_LO) || (d_addr > ADDR_HI);
  assign pick_i  = if_req && (!d_req || (starve_q == STARVE_MAX));
  assign pick_d  = d_req && !pick_i;
  assign grant_i = (state_q == IDLE) && pick_i;
  assign grant_d = (state_q == IDLE) && pick_d && !d_oob;
  assign oob_hit = (state_q == IDLE) && pick_d && d_oob;

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    starve_d    = starve_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    if_valid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_valid_d   = 1'b0;
    d_rdata_d   = d_rdata_q;
    err_oob_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_i) begin
          state_d     = BUSY_I;
          lat_d       = LAT_LOAD;
          mem_addr_d  = if_addr;
          mem_wdata_d = d_wdata;
          mem_we_d    = 1'b0;
          starve_d    = '0;
        end else if (pick_d) begin
          if (if_req && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 4'd1;
          end
          if (d_oob) begin
            // Rejected without touching memory; answer on the next cycle.
            d_valid_d = 1'b1;
            err_oob_d = 1'b1;
            d_rdata_d = '0;
          end else begin
            state_d     = BUSY_D;
            lat_d       = LAT_LOAD;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_we_d    = d_we;
          end
        end
      end
      BUSY_I: begin
        if (lat_q == 4'd0) begin
          if_valid_d = 1'b1;
          if_rdata_d = mem_rdata;
          state_d    = IDLE;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      BUSY_D: begin
        if (lat_q == 4'd0) begin
          d_valid_d = 1'b1;
          d_rdata_d = mem_rdata;
          mem_we_d  = 1'b0;
          state_d   = IDLE;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      default: begin
        state_d  = IDLE;
        mem_we_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      starve_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      if_valid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_valid_q   <= 1'b0;
      d_rdata_q   <= '0;
      err_oob_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      starve_q    <= starve_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      if_valid_q  <= if_valid_d;
      if_rdata_q  <= if_rdata_d;
      d_valid_q   <= d_valid_d;
      d_rdata_q   <= d_rdata_d;
      err_oob_q   <= err_oob_d;
    end
  end

`ifdef MEM_ARB_TRACE_EN
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (grant_i) begin
        $display("arb: %s addr=%x we=%b wdata=%x", "I", if_addr, 1'b0, d_wdata);
      end
      if (grant_d) begin
        $display("arb: %s addr=%x we=%b wdata=%x", "D", d_addr, d_we, d_wdata);
      end
      if (err_oob_q) begin
        $display("arb: oob addr=%x", d_addr);
      end
    end
  end
`else
  logic unused_trace;
  assign unused_trace = oob_hit;
`endif

  assign if_valid  = if_valid_q;
  assign if_rdata  = if_rdata_q;
  assign d_valid   = d_valid_q;
  assign d_rdata   = d_rdata_q;
  assign err_oob   = err_oob_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign stall_if  = if_req & ~if_valid_q;
  assign stall_mem = d_req & ~d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed literal checks plus randomized traffic against a timing/priority model.
module tb_mem_port_arbiter;
  localparam logic [31:0] LO = 32'h00400000;
  localparam logic [31:0] HI = 32'h0041FFFF;
  localparam int LAT   = 1;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // main instance (MEM_LATENCY=1)
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic        if_valid, d_valid, stall_if, stall_mem, mem_we, err_oob;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  // second instance (MEM_LATENCY=4)
  logic        rst4_n = 1'b0;
  logic        if_req4 = 1'b0, d_req4 = 1'b0, d_we4 = 1'b0;
  logic [31:0] if_addr4 = '0, d_addr4 = '0, d_wdata4 = '0;
  logic        if_valid4, d_valid4, stall_if4, stall_mem4, mem_we4, err_oob4;
  logic [31:0] if_rdata4, d_rdata4, mem_addr4, mem_wdata4, mem_rdata4;

  mem_port_arbiter #(.ADDR_LO(LO), .ADDR_HI(HI), .MEM_LATENCY(LAT), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(d_valid), .d_rdata(d_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .err_oob(err_oob)
  );

  mem_port_arbiter #(.ADDR_LO(LO), .ADDR_HI(HI), .MEM_LATENCY(4), .STARVE_LIMIT(LIMIT)) dut4 (
    .clk(clk), .rst_n(rst4_n),
    .if_req(if_req4), .if_addr(if_addr4), .if_valid(if_valid4), .if_rdata(if_rdata4),
    .d_req(d_req4), .d_we(d_we4), .d_addr(d_addr4), .d_wdata(d_wdata4),
    .d_valid(d_valid4), .d_rdata(d_rdata4),
    .stall_if(stall_if4), .stall_mem(stall_mem4),
    .mem_addr(mem_addr4), .mem_we(mem_we4), .mem_wdata(mem_wdata4), .mem_rdata(mem_rdata4),
    .err_oob(err_oob4)
  );

  function automatic logic [31:0] init_word(input logic [9:0] i);
    return (i == 10'd0) ? 32'h2408000A : {6'h15, i, 6'h2A, i};
  endfunction

  // bench memory for the main instance
  logic [31:0] mem_arr [0:1023];
  bit          mem_wr  [0:1023];
  assign mem_rdata = mem_wr[mem_addr[11:2]] ? mem_arr[mem_addr[11:2]] : init_word(mem_addr[11:2]);
  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      mem_arr[mem_addr[11:2]] <= mem_wdata;
      mem_wr[mem_addr[11:2]]  <= 1'b1;
    end
  end

  assign mem_rdata4 = mem_addr4 ^ 32'hA5A50000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (main instance) ----------------
  bit [31:0]   m_mem [0:1023];
  bit          m_wr  [0:1023];
  int          m_owner = 0;   // 0 none, 1 fetch, 2 data
  int          m_left  = 0;   // edges until completion
  int          m_starve = 0;
  logic        g_we = 1'b0;
  logic        e_if_valid = 1'b0, e_d_valid = 1'b0, e_err = 1'b0, e_mem_we = 1'b0;
  logic        e_d_load = 1'b0, e_in_rst = 1'b0;
  logic [31:0] e_if_rdata = '0, e_d_rdata = '0, e_mem_addr = '0, e_mem_wdata = '0;

  function automatic logic [31:0] m_read(input logic [31:0] a);
    return m_wr[a[11:2]] ? m_mem[a[11:2]] : init_word(a[11:2]);
  endfunction

  always @(posedge clk) begin
    e_if_valid = 1'b0; e_d_valid = 1'b0; e_err = 1'b0; e_d_load = 1'b0; e_in_rst = 1'b0;
    if (!rst_n) begin
      m_owner = 0; m_starve = 0; e_in_rst = 1'b1;
      e_mem_we = 1'b0; e_mem_addr = '0; e_mem_wdata = '0; e_if_rdata = '0; e_d_rdata = '0;
    end else if (m_owner != 0) begin
      m_left--;
      if (m_left == 0) begin
        if (m_owner == 1) begin
          e_if_valid = 1'b1;
          e_if_rdata = m_read(e_mem_addr);
        end else begin
          e_d_valid = 1'b1;
          e_d_load  = !g_we;
          if (!g_we) e_d_rdata = m_read(e_mem_addr);
        end
        e_mem_we = 1'b0;
        m_owner  = 0;
      end
    end else if (if_req && (!d_req || m_starve == LIMIT)) begin
      m_owner = 1; m_left = LAT; m_starve = 0;
      e_mem_addr = if_addr; e_mem_we = 1'b0; e_mem_wdata = d_wdata;
    end else if (d_req) begin
      if (if_req && m_starve < LIMIT) m_starve++;
      if (d_addr < LO || d_addr > HI) begin
        e_d_valid = 1'b1; e_err = 1'b1; e_d_rdata = '0; e_d_load = 1'b1;
      end else begin
        m_owner = 2; m_left = LAT; g_we = d_we;
        e_mem_addr = d_addr; e_mem_we = d_we; e_mem_wdata = d_wdata;
        if (d_we) begin
          m_mem[d_addr[11:2]] = d_wdata;
          m_wr[d_addr[11:2]]  = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check1("if_valid", if_valid, e_if_valid);
      check1("d_valid", d_valid, e_d_valid);
      check1("err_oob", err_oob, e_err);
      check1("mem_we", mem_we, e_mem_we);
      check1("stall_if", stall_if, if_req & ~e_if_valid);
      check1("stall_mem", stall_mem, d_req & ~e_d_valid);
      if (e_if_valid) check("if_rdata", if_rdata, e_if_rdata);
      if (e_d_valid && e_d_load) check("d_rdata", d_rdata, e_d_rdata);
      if (m_owner != 0) begin
        check("mem_addr", mem_addr, e_mem_addr);
        check("mem_wdata", mem_wdata, e_mem_wdata);
      end
      if (e_in_rst) begin
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_access(input bit is_d, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                           output int lat, output logic [31:0] rdata, output int we_cnt,
                           output bit err, output int stall_cnt);
    bit found;
    found = 1'b0; lat = -1; rdata = '0; we_cnt = 0; err = 1'b0; stall_cnt = 0;
    if (is_d) begin
      d_we = we; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
    end else begin
      if_addr = addr; if_req = 1'b1;
    end
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (is_d ? d_valid : if_valid) begin
        found = 1'b1; lat = k; rdata = is_d ? d_rdata : if_rdata; err = err_oob;
        #1;
        if (is_d) d_req = 1'b0; else if_req = 1'b0;
      end else begin
        we_cnt += int'(mem_we);
        stall_cnt += int'(is_d ? stall_mem : stall_if);
        tick();
      end
    end
    if (!found) begin
      check1("access_timeout", 1'b0, 1'b1);
      d_req = 1'b0; if_req = 1'b0;
    end
    tick();
  endtask

  task automatic fetch4(input logic [31:0] addr);
    int lat;
    int stab;
    lat = -1; stab = 0;
    if_addr4 = addr; if_req4 = 1'b1;
    for (int k = 0; k < 40 && lat < 0; k++) begin
      @(negedge clk);
      if (if_valid4) begin
        lat = k;
        check("l4_if_rdata", if_rdata4, addr ^ 32'hA5A50000);
        #1;
        if_req4 = 1'b0;
      end else begin
        if (k >= 1 && mem_addr4 == addr) stab++;
        tick();
      end
    end
    check("l4_latency", 32'(lat), 32'd5);
    check("l4_addr_stable", 32'(stab), 32'd4);
    if_req4 = 1'b0;
    tick();
  endtask

  task automatic new_fetch();
    if_req  = 1'b1;
    if_addr = LO + 32'($urandom_range(0, 1023)) * 32'd4;
  endtask

  task automatic new_data();
    int r;
    r = $urandom_range(0, 9);
    d_req   = 1'b1;
    d_we    = 1'($urandom_range(0, 1));
    d_wdata = $urandom;
    if (r == 0)      d_addr = LO;
    else if (r == 1) d_addr = 32'h0041FFFC;
    else             d_addr = LO + 32'($urandom_range(0, 1023)) * 32'd4;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, we_cnt, stall_cnt, nv, cnt;
    logic [31:0] rd;
    bit err;
    logic [9:0] ord;
    logic [31:0] oob_tab [3];
    oob_tab[0] = 32'h00000010; oob_tab[1] = 32'h00420000; oob_tab[2] = 32'h003FFFFC;

    tick();
    chk_en = 1'b1;
    tick(); tick();
    check1("rst_if_valid", if_valid, 1'b0);
    check1("rst_d_valid", d_valid, 1'b0);
    check1("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr_lit", mem_addr, 32'h0);
    check1("rst4_if_valid", if_valid4, 1'b0);
    check("rst4_mem_addr", mem_addr4, 32'h0);
    rst_n = 1'b1; rst4_n = 1'b1;
    tick();

    // fetch only
    do_access(1'b0, 1'b0, LO, 32'h0, lat, rd, we_cnt, err, stall_cnt);
    check("fetch_latency", 32'(lat), 32'd2);
    check("fetch_rdata", rd, 32'h2408000A);
    check("fetch_stall_cycles", 32'(stall_cnt), 32'd2);
    check("fetch_we_cycles", 32'(we_cnt), 32'd0);

    // store then load
    do_access(1'b1, 1'b1, 32'h00410040, 32'hDEADBEEF, lat, rd, we_cnt, err, stall_cnt);
    check("store_latency", 32'(lat), 32'd2);
    check("store_we_cycles", 32'(we_cnt), 32'd1);
    check1("store_err", err, 1'b0);
    do_access(1'b1, 1'b0, 32'h00410040, 32'h0, lat, rd, we_cnt, err, stall_cnt);
    check("load_rdata", rd, 32'hDEADBEEF);
    check("load_we_cycles", 32'(we_cnt), 32'd0);

    // highest in-range word
    do_access(1'b1, 1'b0, 32'h0041FFFC, 32'h0, lat, rd, we_cnt, err, stall_cnt);
    check("hi_load_latency", 32'(lat), 32'd2);
    check("hi_load_rdata", rd, init_word(10'h3FF));
    check1("hi_load_err", err, 1'b0);

    // out of range
    for (int i = 0; i < 3; i++) begin
      do_access(1'b1, 1'b0, oob_tab[i], 32'h0, lat, rd, we_cnt, err, stall_cnt);
      check("oob_latency", 32'(lat), 32'd1);
      check1("oob_err", err, 1'b1);
      check("oob_rdata", rd, 32'h0);
      check("oob_we_cycles", 32'(we_cnt), 32'd0);
    end

    // contention
    if_addr = LO + 32'h100; d_addr = LO + 32'h200; d_we = 1'b0; d_wdata = 32'h0;
    if_req = 1'b1; d_req = 1'b1;
    ord = '0; nv = 0; cnt = 0;
    for (int k = 0; k < 200 && nv < 10; k++) begin
      @(negedge clk);
      cnt += int'(mem_we);
      if (d_valid || if_valid) begin
        ord = {ord[8:0], d_valid};
        nv++;
        if (nv == 10) begin
          #1;
          if_req = 1'b0; d_req = 1'b0;
        end
      end
      tick();
    end
    check("contention_count", 32'(nv), 32'd10);
    check("grant_order", 32'(ord), 32'(10'b1111011110));
    check("contention_we", 32'(cnt), 32'd0);
    repeat (4) tick();

    // latency 4 instance: fetch latency and mem_addr stability
    fetch4(LO + 32'h40);

    // reset in the second busy cycle of a store
    d_we4 = 1'b1; d_addr4 = LO + 32'h80; d_wdata4 = 32'h12345678; d_req4 = 1'b1;
    tick(); tick();
    @(negedge clk);
    check1("l4_store_busy_we", mem_we4, 1'b1);
    #1;
    rst4_n = 1'b0; d_req4 = 1'b0;
    tick();
    @(negedge clk);
    check1("l4_rst_if_valid", if_valid4, 1'b0);
    check1("l4_rst_d_valid", d_valid4, 1'b0);
    check1("l4_rst_err", err_oob4, 1'b0);
    check1("l4_rst_mem_we", mem_we4, 1'b0);
    check("l4_rst_mem_addr", mem_addr4, 32'h0);
    check("l4_rst_mem_wdata", mem_wdata4, 32'h0);
    check("l4_rst_if_rdata", if_rdata4, 32'h0);
    check("l4_rst_d_rdata", d_rdata4, 32'h0);
    check1("l4_rst_stall_if", stall_if4, 1'b0);
    check1("l4_rst_stall_mem", stall_mem4, 1'b0);
    #1;
    rst4_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      @(negedge clk);
      cnt += int'(d_valid4) + int'(mem_we4);
    end
    check("l4_after_rst_activity", 32'(cnt), 32'd0);
    tick();
    fetch4(LO + 32'h44);

    // randomized traffic on the main instance
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (if_req && if_valid) begin
        if ($urandom_range(0, 1) == 1) new_fetch(); else if_req = 1'b0;
      end else if (!if_req && $urandom_range(0, 3) == 0) begin
        new_fetch();
      end
      if (d_req && d_valid) begin
        if ($urandom_range(0, 1) == 1) new_data(); else d_req = 1'b0;
      end else if (!d_req && $urandom_range(0, 2) == 0) begin
        new_data();
      end
      tick();
    end
    if_req = 1'b0; d_req = 1'b0;
    repeat (8) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
